// File: rtl/uart_slave_pkg.sv
// uart_slave_pkg
//   Shared definitions for the memory-mapped UART bus slave:
//   - bus widths used by the slave port
//   - register offsets (word index taken from addr[4:2])
//   - TX and RX state encodings
//   - clamp_baud helper used when software writes the divisor
package uart_slave_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MASK_WIDTH = 4;

  localparam logic [2:0] UART_CTRL   = 3'd0;
  localparam logic [2:0] UART_STATUS = 3'd1;
  localparam logic [2:0] UART_BAUD   = 3'd2;
  localparam logic [2:0] UART_TXDATA = 3'd3;
  localparam logic [2:0] UART_RXDATA = 3'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // A divisor below the minimum cannot give a usable mid-bit sample point.
  function automatic logic [15:0] clamp_baud(input logic [15:0] value,
                                             input logic [15:0] min_value);
    return (value < min_value) ? min_value : value;
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
//   8N1 receiver: 2-flop synchroniser, start-bit glitch filter, bit timer and
//   LSB-first shifter. Reports every completed frame with the sampled stop bit.
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx_en        allows new frames to start (a running frame always completes)
//   baud_div     clk cycles per bit, latched when a frame starts
//   rx_i         asynchronous serial input, idle high
//   frame_done   one-cycle pulse when the stop bit is sampled
//   stop_ok      value of the stop bit, valid with frame_done
//   rx_byte      received byte, valid with frame_done
module uart_rx_fsm
  import uart_slave_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic [15:0] baud_div,
  input  logic        rx_i,
  output logic        frame_done,
  output logic        stop_ok,
  output logic [7:0]  rx_byte
);

  rx_state_t   rx_state, rx_next;
  logic        rx_meta, rx_s, rx_prev;
  logic [15:0] rx_div, rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shreg;
  logic        start_edge, half_last, bit_last;

  assign start_edge = rx_en & rx_prev & ~rx_s;
  assign half_last  = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign bit_last   = (rx_cnt == rx_div - 16'd1);

  // Synchroniser plus one extra flop so a falling edge can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Next state. A line that is high again at half a bit was only a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (start_edge) rx_next = RX_START;
      RX_START: if (half_last)  rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_last && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_last)   rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timer and shifter; after the half-bit wait, samples land mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_div   <= 16'd16;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (start_edge) rx_div <= baud_div;
        end
        RX_START: rx_cnt <= half_last ? 16'd0 : rx_cnt + 16'd1;
        RX_DATA: begin
          if (bit_last) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s, rx_shreg[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: rx_cnt <= bit_last ? 16'd0 : rx_cnt + 16'd1;
        default: rx_cnt <= '0;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    frame_done = (rx_state == RX_STOP) && bit_last;
    stop_ok    = rx_s;
    rx_byte    = rx_shreg;
  end

endmodule

// File: rtl/uart_slave.sv
// uart_slave
//   Bus slave UART: register file, bus handshake, 8N1 transmitter, and the
//   uart_rx_fsm receiver. Level interrupt while a received byte is unread.
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   req_i, we_i        bus request, 1 = write
//   addr_i             byte address, word index addr_i[4:2]
//   data_i, wem        write data and byte enables
//   data_o             read data, valid with data_ok
//   addr_ok, data_ok   request accepted / response one cycle later
//   uart_tx_o          serial out, idle high
//   uart_rx_i          serial in
//   int_sig_o          rx_valid & rx_ie
module uart_slave
  import uart_slave_pkg::*;
#(
  parameter int BAUD_DIV_RST = 434,
  parameter int BAUD_DIV_MIN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [BUS_WIDTH-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [MASK_WIDTH-1:0] wem,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic                  uart_tx_o,
  input  logic                  uart_rx_i,
  output logic                  int_sig_o
);

  localparam logic [15:0] BAUD_RST_V = 16'(BAUD_DIV_RST);
  localparam logic [15:0] BAUD_MIN_V = 16'(BAUD_DIV_MIN);

  logic        tx_en, rx_en, rx_ie;
  logic [15:0] baud, baud_wr;
  logic        rx_valid, overrun, frame_err;
  logic [7:0]  rx_data;
  logic [2:0]  reg_sel;
  logic        wr_acc, rd_acc, tx_load, rx_read, status_clr;
  logic [DATA_WIDTH-1:0] rd_data;

  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shreg;
  logic        tx_busy, tx_last;

  logic        frame_done, stop_ok;
  logic [7:0]  rx_byte;
  logic        unused_bits;

  assign unused_bits = ^{addr_i[BUS_WIDTH-1:5], addr_i[1:0], data_i[DATA_WIDTH-1:16], wem[3:2]};

  assign addr_ok    = req_i;
  assign reg_sel    = addr_i[4:2];
  assign wr_acc     = req_i & we_i;
  assign rd_acc     = req_i & ~we_i;
  assign tx_load    = wr_acc && reg_sel == UART_TXDATA && wem[0] && tx_en && !tx_busy;
  assign rx_read    = rd_acc && reg_sel == UART_RXDATA;
  assign status_clr = wr_acc && reg_sel == UART_STATUS && wem[0];
  assign baud_wr    = {wem[1] ? data_i[15:8] : baud[15:8], wem[0] ? data_i[7:0] : baud[7:0]};
  assign int_sig_o  = rx_valid & rx_ie;

  // Read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      UART_CTRL:   rd_data[2:0]  = {rx_ie, rx_en, tx_en};
      UART_STATUS: rd_data[3:0]  = {frame_err, overrun, rx_valid, tx_busy};
      UART_BAUD:   rd_data[15:0] = baud;
      UART_RXDATA: rd_data[7:0]  = rx_data;
      default:     rd_data = '0;
    endcase
  end

  // Every request is answered on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_ok <= 1'b0;
      data_o  <= '0;
    end else begin
      data_ok <= req_i;
      if (rd_acc)      data_o <= rd_data;
      else if (wr_acc) data_o <= '0;
    end
  end

  // CTRL and BAUD registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rx_ie, rx_en, tx_en} <= 3'b000;
      baud <= BAUD_RST_V;
    end else if (wr_acc) begin
      if (reg_sel == UART_CTRL && wem[0]) {rx_ie, rx_en, tx_en} <= data_i[2:0];
      if (reg_sel == UART_BAUD && |wem[1:0]) baud <= clamp_baud(baud_wr, BAUD_MIN_V);
    end
  end

  // Receive status. A frame completing in the same cycle as an RXDATA read
  // is stored and keeps rx_valid set without flagging an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      if (frame_done && stop_ok) rx_valid <= 1'b1;
      else if (rx_read)          rx_valid <= 1'b0;

      if (frame_done && stop_ok && (!rx_valid || rx_read)) rx_data <= rx_byte;

      if (frame_done && stop_ok && rx_valid && !rx_read) overrun <= 1'b1;
      else if (status_clr && data_i[2])                  overrun <= 1'b0;

      if (frame_done && !stop_ok)       frame_err <= 1'b1;
      else if (status_clr && data_i[3]) frame_err <= 1'b0;
    end
  end

  assign tx_last = (tx_cnt == tx_div - 16'd1);

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // TX next state; each state (and each data bit) lasts tx_div cycles.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_next = TX_START;
      TX_START: if (tx_last) tx_next = TX_DATA;
      TX_DATA:  if (tx_last && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_last) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX bit timer and shifter; the divisor is captured when the byte loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_div   <= BAUD_RST_V;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      if (tx_load) begin
        tx_div   <= baud;
        tx_shreg <= data_i[7:0];
      end
    end else if (tx_last) begin
      tx_cnt <= '0;
      if (tx_state == TX_DATA) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  // TX outputs decoded from state, so reset drives the line high at once.
  always_comb begin
    tx_busy   = (tx_state != TX_IDLE);
    uart_tx_o = 1'b1;
    case (tx_state)
      TX_START: uart_tx_o = 1'b0;
      TX_DATA:  uart_tx_o = tx_shreg[0];
      default:  uart_tx_o = 1'b1;
    endcase
  end

  uart_rx_fsm u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_en      (rx_en),
    .baud_div   (baud),
    .rx_i       (uart_rx_i),
    .frame_done (frame_done),
    .stop_ok    (stop_ok),
    .rx_byte    (rx_byte)
  );

endmodule
